regfile_reader: RTL and testbench

REGFILE_READER -- requirements
Module: regfile_reader

---
 rtl/regfile_reader_if.sv | 46 ++++
 rtl/regfile_reader.sv | 115 +++++++++++
 tb/tb_regfile_reader.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_reader_if.sv
// rtl/regfile_reader_if.sv - decode/regfile/write-back/execute bundle for regfile_reader
interface regfile_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic        req_rd_we;

  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;

  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        out_rd_we;

  logic        flush;
  logic [31:0] busy;

  modport slave (
    input  req_valid, req_rs, req_rt, req_rd, req_rd_we,
    input  rf_rdata1, rf_rdata2,
    input  wb_we, wb_addr, wb_data,
    input  out_ready, flush,
    output req_ready, rf_raddr1, rf_raddr2,
    output out_valid, out_a, out_b, out_rd, out_rd_we, busy
  );

  modport master (
    output req_valid, req_rs, req_rt, req_rd, req_rd_we,
    output rf_rdata1, rf_rdata2,
    output wb_we, wb_addr, wb_data,
    output out_ready, flush,
    input  req_ready, rf_raddr1, rf_raddr2,
    input  out_valid, out_a, out_b, out_rd, out_rd_we, busy
  );
endinterface

// File: rtl/regfile_reader.sv
// rtl/regfile_reader.sv - operand fetch stage with scoreboard; REGFILE_READER_BYPASS_EN enables write-back bypass
module regfile_reader (
  input  logic       clk,
  input  logic       reset,
  regfile_reader_if.slave bus
);

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_a_q, out_a_d;
  logic [31:0] out_b_q, out_b_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_rd_we_q, out_rd_we_d;
  logic [31:0] busy_q, busy_d;

  logic        rs_nz, rt_nz;
  logic        rs_busy, rt_busy;
  logic        rs_byp, rt_byp;
  logic        stall;
  logic        req_ready;
  logic        accept;
  logic [31:0] opnd_a, opnd_b;

  // Operand resolution: zero register, write-back bypass, hazard detection
  always_comb begin
    rs_nz   = (bus.req_rs != 5'd0);
    rt_nz   = (bus.req_rt != 5'd0);
    rs_busy = rs_nz && busy_q[bus.req_rs];
    rt_busy = rt_nz && busy_q[bus.req_rt];
`ifdef REGFILE_READER_BYPASS_EN
    rs_byp  = rs_nz && bus.wb_we && (bus.wb_addr == bus.req_rs);
    rt_byp  = rt_nz && bus.wb_we && (bus.wb_addr == bus.req_rt);
`else
    // Without the bypass a matching write-back only resolves the hazard
    // once the array holds the value, i.e. on the following cycle.
    rs_byp  = 1'b0;
    rt_byp  = 1'b0;
`endif
    stall     = bus.req_valid && ((rs_busy && !rs_byp) || (rt_busy && !rt_byp));
    req_ready = !bus.flush && !stall && (!out_valid_q || bus.out_ready);
    accept    = bus.req_valid && req_ready;

    if (!rs_nz)      opnd_a = 32'd0;
    else if (rs_byp) opnd_a = bus.wb_data;
    else             opnd_a = bus.rf_rdata1;

    if (!rt_nz)      opnd_b = 32'd0;
    else if (rt_byp) opnd_b = bus.wb_data;
    else             opnd_b = bus.rf_rdata2;
  end

  // Scoreboard update: write-back and flush clear, accept sets last so it wins
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_we) begin
      busy_d[bus.wb_addr] = 1'b0;
    end
    if (bus.flush && out_valid_q && out_rd_we_q) begin
      busy_d[out_rd_q] = 1'b0;
    end
    if (accept && bus.req_rd_we) begin
      busy_d[bus.req_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Output entry: flush kills, accept replaces, a consumed entry drops
  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_rd_d    = out_rd_q;
    out_rd_we_d = out_rd_we_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_a_d     = opnd_a;
      out_b_d     = opnd_b;
      out_rd_d    = bus.req_rd;
      out_rd_we_d = bus.req_rd_we;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_a_q     <= 32'd0;
      out_b_q     <= 32'd0;
      out_rd_q    <= 5'd0;
      out_rd_we_q <= 1'b0;
      busy_q      <= 32'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_rd_q    <= out_rd_d;
      out_rd_we_q <= out_rd_we_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rf_raddr1 = bus.req_rs;
  assign bus.rf_raddr2 = bus.req_rt;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_rd_we = out_rd_we_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_regfile_reader.sv
// tb/tb_regfile_reader.sv - self-checking bench for regfile_reader
module tb_regfile_reader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] regs [32];

  regfile_reader_if bus ();

  regfile_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural register array: combinational read, write on rising edge
  assign bus.rf_rdata1 = regs[bus.rf_raddr1];
  assign bus.rf_rdata2 = regs[bus.rf_raddr2];
  always @(posedge clk) begin
    if (bus.wb_we) regs[bus.wb_addr] <= bus.wb_data;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0; bus.req_rs = 5'd0; bus.req_rt = 5'd0;
    bus.req_rd = 5'd0; bus.req_rd_we = 1'b0;
    bus.wb_we = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
    bus.out_ready = 1'b1; bus.flush = 1'b0;
  endtask

  task automatic set_req(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic we);
    bus.req_valid = v; bus.req_rs = rs; bus.req_rt = rt;
    bus.req_rd = rd; bus.req_rd_we = we;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.wb_we = we; bus.wb_addr = a; bus.wb_data = d;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      set_wb(1'b1, 5'(i), (i == 0) ? 32'hFFFF_FFFF : $urandom);
      next_cycle();
    end
    set_wb(1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_a !== 32'd0 || bus.out_b !== 32'd0 ||
        bus.out_rd !== 5'd0 || bus.out_rd_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b a=%h b=%h rd=%0d we=%b, required all zero",
               bus.out_valid, bus.out_a, bus.out_b, bus.out_rd, bus.out_rd_we);
    end
    checks++;
    if (bus.busy !== 32'd0) begin
      failures++;
      $display("FAIL reset_busy: got %h required 0", bus.busy);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b required 1", bus.req_ready);
    end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_plain_read();
    set_wb(1'b1, 5'd3, 32'h11); next_cycle();
    set_wb(1'b1, 5'd4, 32'h22); next_cycle();
    set_wb(1'b0, 5'd0, 32'd0);
    set_req(1'b1, 5'd3, 5'd4, 5'd0, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL plain_ready: got %b required 1", bus.req_ready);
    end
    next_cycle();
    set_req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_a !== 32'h11 || bus.out_b !== 32'h22) begin
      failures++;
      $display("FAIL plain_read: valid=%b a=%h b=%h required 1 11 22",
               bus.out_valid, bus.out_a, bus.out_b);
    end
    next_cycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL plain_drain: out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_hazard();
    bus.out_ready = 1'b1;
    set_req(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    next_cycle();
    checks++;
    if (bus.busy[7] !== 1'b1) begin
      failures++;
      $display("FAIL hazard_set: busy[7]=%b required 1", bus.busy[7]);
    end
    set_req(1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hazard_stall: cycle %0d req_ready=%b required 0", i, bus.req_ready);
      end
      next_cycle();
    end
    set_wb(1'b1, 5'd7, 32'hDEAD);
    @(negedge clk);
`ifdef REGFILE_READER_BYPASS_EN
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL hazard_bypass_ready: got %b required 1", bus.req_ready);
    end
    next_cycle();
    set_wb(1'b0, 5'd0, 32'd0);
    set_req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
`else
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL hazard_wb_cycle_ready: got %b required 0", bus.req_ready);
    end
    next_cycle();
    set_wb(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL hazard_after_wb_ready: got %b required 1", bus.req_ready);
    end
    next_cycle();
    set_req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
`endif
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_a !== 32'hDEAD || bus.busy[7] !== 1'b0) begin
      failures++;
      $display("FAIL hazard_result: valid=%b a=%h busy7=%b required 1 dead 0",
               bus.out_valid, bus.out_a, bus.busy[7]);
    end
    next_cycle();
  endtask

  task automatic test_zero_reg();
    bus.out_ready = 1'b1;
    set_req(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    next_cycle();
    set_req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_a !== 32'd0 || bus.out_b !== 32'd0 || bus.busy !== 32'd0) begin
      failures++;
      $display("FAIL zero_reg: valid=%b a=%h b=%h busy=%h required 1 0 0 0",
               bus.out_valid, bus.out_a, bus.out_b, bus.busy);
    end
    next_cycle();
  endtask

  task automatic test_backpressure_flush();
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    exp_a = regs[1];
    exp_b = regs[2];
    bus.out_ready = 1'b0;
    set_req(1'b1, 5'd1, 5'd2, 5'd9, 1'b1);
    next_cycle();
    set_req(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    set_wb(1'b1, 5'd1, 32'hBADC0DE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_a !== exp_a || bus.out_b !== exp_b ||
          bus.out_rd !== 5'd9 || bus.out_rd_we !== 1'b1 || bus.req_ready !== 1'b0 ||
          bus.busy[9] !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d valid=%b a=%h b=%h rd=%0d we=%b ready=%b busy9=%b required 1 %h %h 9 1 0 1",
                 i, bus.out_valid, bus.out_a, bus.out_b, bus.out_rd, bus.out_rd_we,
                 bus.req_ready, bus.busy[9], exp_a, exp_b);
      end
      next_cycle();
    end
    set_wb(1'b0, 5'd0, 32'd0);
    set_req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    next_cycle();
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy[9] !== 1'b0) begin
      failures++;
      $display("FAIL flush: valid=%b busy9=%b required 0 0", bus.out_valid, bus.busy[9]);
    end
  endtask

  task automatic test_collision();
    bus.out_ready = 1'b1;
    set_req(1'b1, 5'd0, 5'd0, 5'd12, 1'b1);
    set_wb(1'b1, 5'd12, 32'h1234);
    next_cycle();
    set_req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++;
    if (bus.busy[12] !== 1'b1) begin
      failures++;
      $display("FAIL collision: busy[12]=%b required 1", bus.busy[12]);
    end
    next_cycle();
    set_wb(1'b0, 5'd0, 32'd0);
    checks++;
    if (bus.busy !== 32'd0) begin
      failures++;
      $display("FAIL collision_clear: busy=%h required 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_hold();
    bus.out_ready = 1'b0;
    set_req(1'b1, 5'd3, 5'd4, 5'd5, 1'b1);
    next_cycle();
    set_req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_a !== 32'd0 || bus.out_b !== 32'd0 ||
        bus.out_rd !== 5'd0 || bus.out_rd_we !== 1'b0 || bus.busy !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_hold: valid=%b a=%h b=%h rd=%0d we=%b busy=%h required all zero",
               bus.out_valid, bus.out_a, bus.out_b, bus.out_rd, bus.out_rd_we, bus.busy);
    end
    next_cycle();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    set_req(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
    next_cycle();
    set_req(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_a !== regs[3]) begin
      failures++;
      $display("FAIL reset_release_accept: valid=%b a=%h required 1 %h",
               bus.out_valid, bus.out_a, regs[3]);
    end
    next_cycle();
  endtask

  task automatic test_random();
    logic        m_valid, m_rd_we;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_rd;
    logic        m_busy [32];
    logic        n_valid, n_rd_we;
    logic [31:0] n_a, n_b;
    logic [4:0]  n_rd;
    logic        n_busy [32];
    logic        byp, unres_s, unres_t, exp_ready, acc;
    logic [31:0] exp_busy;
`ifdef REGFILE_READER_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    idle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    m_valid = 0; m_rd_we = 0; m_a = 0; m_b = 0; m_rd = 0;
    foreach (m_busy[k]) m_busy[k] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      set_req(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1));
      set_wb(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flush = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      // An operand waits when its register is owed a value that is not arriving right now.
      unres_s = (bus.req_rs != 0) && m_busy[bus.req_rs] &&
                !(byp && bus.wb_we && bus.wb_addr == bus.req_rs);
      unres_t = (bus.req_rt != 0) && m_busy[bus.req_rt] &&
                !(byp && bus.wb_we && bus.wb_addr == bus.req_rt);
      exp_ready = !bus.flush && !(bus.req_valid && (unres_s || unres_t)) &&
                  (!m_valid || bus.out_ready);
      acc = bus.req_valid && exp_ready;
      exp_busy = 32'd0;
      for (int k = 0; k < 32; k++) exp_busy[k] = m_busy[k];
      checks++;
      if (bus.req_ready !== exp_ready || bus.out_valid !== m_valid || bus.busy !== exp_busy) begin
        failures++;
        $display("FAIL rand_ctrl: cyc %0d ready=%b valid=%b busy=%h required %b %b %h",
                 cyc, bus.req_ready, bus.out_valid, bus.busy, exp_ready, m_valid, exp_busy);
      end
      if (m_valid) begin
        checks++;
        if (bus.out_a !== m_a || bus.out_b !== m_b || bus.out_rd !== m_rd || bus.out_rd_we !== m_rd_we) begin
          failures++;
          $display("FAIL rand_data: cyc %0d a=%h b=%h rd=%0d we=%b required %h %h %0d %b",
                   cyc, bus.out_a, bus.out_b, bus.out_rd, bus.out_rd_we, m_a, m_b, m_rd, m_rd_we);
        end
      end
      n_valid = m_valid; n_a = m_a; n_b = m_b; n_rd = m_rd; n_rd_we = m_rd_we;
      n_busy = m_busy;
      if (bus.wb_we && bus.wb_addr != 0) n_busy[bus.wb_addr] = 1'b0;
      if (bus.flush) begin
        if (m_valid && m_rd_we && m_rd != 0) n_busy[m_rd] = 1'b0;
        n_valid = 1'b0;
      end else if (acc) begin
        n_valid = 1'b1;
        n_a = (bus.req_rs == 0) ? 32'd0 :
              (byp && bus.wb_we && bus.wb_addr == bus.req_rs) ? bus.wb_data : regs[bus.req_rs];
        n_b = (bus.req_rt == 0) ? 32'd0 :
              (byp && bus.wb_we && bus.wb_addr == bus.req_rt) ? bus.wb_data : regs[bus.req_rt];
        n_rd = bus.req_rd;
        n_rd_we = bus.req_rd_we;
        if (bus.req_rd_we && bus.req_rd != 0) n_busy[bus.req_rd] = 1'b1;
      end else if (m_valid && bus.out_ready) begin
        n_valid = 1'b0;
      end
      next_cycle();
      m_valid = n_valid; m_a = n_a; m_b = n_b; m_rd = n_rd; m_rd_we = n_rd_we;
      m_busy = n_busy;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_plain_read();
    test_hazard();
    test_zero_reg();
    test_backpressure_flush();
    test_collision();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
